alu_multicycle: RTL and testbench

Parametrised multi-cycle ALU, successor to the fixed 8-bit start/state ALU. Handles ADD, SUB, MUL and DIV on WIDTH-bit unsigned operands. MUL runs as an iterative shift-add and DIV as an iterative restoring division. Provides a start/busy/done handshake, a divide-by-zero flag and a visible state code; it sits behind the top-level controller as the arithmetic engine.

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_muldiv_iter.sv | 89 ++++++++
 rtl/alu_multicycle.sv | 126 ++++++++++++
 tb/tb_alu_multicycle.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, FSM state codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = 3'b000,
        S_ADDSUB = 3'b001,
        S_MUL    = 3'b010,
        S_DIV    = 3'b011,
        S_DONE   = 3'b100
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative engine: shift-add multiply (LSB first) or restoring divide (MSB first), one bit per step.
// Latency: WIDTH steps after load; finished is high during the step whose p_nxt is the final value.
// Backpressure: none; the owner drives load/step and consumes p_nxt when finished is high.
//
// Ports: clk, rst (sync, active-high), load (capture operands and mode), div_mode (1=divide),
//        a_in/b_in (multiplicand/multiplier or dividend/divisor), step (advance one iteration),
//        p_nxt (combinational value of the shift register after this step), finished.
module alu_muldiv_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               div_mode,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic               step,
    output logic [2*WIDTH-1:0] p_nxt,
    output logic               finished
);
    import alu_pkg::*;

    localparam int               CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // mul: p = {partial product, remaining multiplier bits}, m = multiplicand
    // div: p = {partial remainder, remaining dividend / growing quotient}, m = divisor
    logic [2*WIDTH-1:0] p_q;
    logic [WIDTH-1:0]   m_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               div_q;

    logic [WIDTH:0]     x;
    logic [WIDTH+1:0]   sum;

    always_comb begin
        // In divide mode the remainder is shifted left with the next dividend bit;
        // it can momentarily need WIDTH+1 bits before the trial subtraction.
        if (div_q) begin
            x   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
            sum = {1'b0, x} - {2'b00, m_q};
        end else begin
            x   = {1'b0, p_q[2*WIDTH-1:WIDTH]};
            sum = {1'b0, x} + {2'b00, m_q};
        end

        p_nxt = p_q;
        if (div_q) begin
            // sum[WIDTH+1] is the borrow: restore (keep x) and shift in a 0 quotient bit
            if (sum[WIDTH+1]) begin
                p_nxt = {x[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            end else begin
                p_nxt = {sum[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Multiplier LSB selects add-then-shift or plain shift; carry enters at the top
            if (p_q[0]) begin
                p_nxt = {sum[WIDTH:0], p_q[WIDTH-1:1]};
            end else begin
                p_nxt = {1'b0, p_q[2*WIDTH-1:1]};
            end
        end
    end

    assign finished = step && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q   <= '0;
            m_q   <= '0;
            cnt_q <= '0;
            div_q <= 1'b0;
        end else if (load) begin
            div_q <= div_mode;
            cnt_q <= '0;
            if (div_mode) begin
                p_q <= {{WIDTH{1'b0}}, a_in};
                m_q <= b_in;
            end else begin
                p_q <= {{WIDTH{1'b0}}, b_in};
                m_q <= a_in;
            end
        end else if (step) begin
            p_q   <= p_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle unsigned ALU (ADD/SUB/MUL/DIV) with start/busy/done handshake and divide-by-zero flag.
// Latency: ADD/SUB 1 edge, MUL WIDTH edges, DIV WIDTH edges (1 edge when b=0) from start to DONE.
// Backpressure: start is sampled only in IDLE; requests in any other state are dropped.
//
// Ports: clk, rst (sync, active-high), start, a, b, op (00 add, 01 sub, 10 mul, 11 div),
//        result (2*WIDTH, held until next completion), busy, done (1-cycle pulse in DONE),
//        div_by_zero, state (current FSM code).
module alu_multicycle #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [1:0]                 op,
    output logic [2*WIDTH-1:0]         result,
    output logic                       busy,
    output logic                       done,
    output logic                       div_by_zero,
    output logic [alu_pkg::STATE_W-1:0] state
);
    import alu_pkg::*;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               sub_q;

    logic               accept;
    logic               it_step;
    logic               it_fin;
    logic [2*WIDTH-1:0] it_res;
    logic [WIDTH:0]     addsub;
    logic [2*WIDTH-1:0] addsub_ext;

    assign accept  = (state_q == S_IDLE) && start;
    assign it_step = (state_q == S_MUL) || (state_q == S_DIV);
    assign state   = state_q;

    // Bit WIDTH is the carry for ADD and the sign for SUB; only SUB replicates it upward.
    assign addsub     = sub_q ? ({1'b0, a_q} - {1'b0, b_q}) : ({1'b0, a_q} + {1'b0, b_q});
    assign addsub_ext = {{(WIDTH-1){sub_q & addsub[WIDTH]}}, addsub};

    // Operands go straight from the ports into the engine on the accepting edge.
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .div_mode (op == OP_DIV),
        .a_in     (a),
        .b_in     (b),
        .step     (it_step),
        .p_nxt    (it_res),
        .finished (it_fin)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            result      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q         <= a;
                        b_q         <= b;
                        sub_q       <= (op == OP_SUB);
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        case (op)
                            OP_ADD, OP_SUB: state_q <= S_ADDSUB;
                            OP_MUL:         state_q <= S_MUL;
                            default:        state_q <= S_DIV;
                        endcase
                    end
                end
                S_ADDSUB: begin
                    result  <= addsub_ext;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_MUL: begin
                    if (it_fin) begin
                        result  <= it_res;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DIV: begin
                    // Zero divisor short-circuits: dividend goes to the remainder slot
                    if (b_q == '0) begin
                        result      <= {a_q, {WIDTH{1'b1}}};
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (it_fin) begin
                        result  <= it_res;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [15:0] a_in, b_in;
    logic [1:0]  op_in;

    logic [15:0] result8;
    logic [31:0] result16;
    logic        busy8, done8, dbz8, busy16, done16, dbz16;
    logic [2:0]  state8, state16;

    int n_checks = 0;
    int n_fail   = 0;
    bit use16    = 1'b0;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a_in[7:0]), .b(b_in[7:0]), .op(op_in),
        .result(result8), .busy(busy8), .done(done8), .div_by_zero(dbz8), .state(state8)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a_in), .b(b_in), .op(op_in),
        .result(result16), .busy(busy16), .done(done16), .div_by_zero(dbz16), .state(state16)
    );

    wire [31:0] c_result = use16 ? result16 : {16'h0, result8};
    wire        c_busy   = use16 ? busy16 : busy8;
    wire        c_done   = use16 ? done16 : done8;
    wire        c_dbz    = use16 ? dbz16  : dbz8;
    wire [2:0]  c_state  = use16 ? state16 : state8;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain arithmetic on W-bit unsigned operands.
    function automatic logic [31:0] model(input int w, input logic [1:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] lo_mask, res_mask;
        lo_mask  = (32'h1 << w) - 1;
        res_mask = (w == 16) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        a = a & lo_mask;
        b = b & lo_mask;
        case (op)
            2'b00:   model = a + b;
            2'b01:   model = (a - b) & res_mask;
            2'b10:   model = a * b;
            default: model = (b == 0) ? ((a << w) | lo_mask) : (((a % b) << w) | (a / b));
        endcase
    endfunction

    function automatic int model_lat(input int w, input logic [1:0] op, input logic [31:0] b);
        logic [31:0] lo_mask;
        lo_mask = (32'h1 << w) - 1;
        if (op[1] == 1'b0) model_lat = 1;
        else if (op == 2'b11 && (b & lo_mask) == 0) model_lat = 1;
        else model_lat = w;
    endfunction

    // Issue one op on the selected instance and check latency, busy span, result, flags, done pulse.
    // mid=1 pulses start with different operands while the op is in flight.
    task automatic run_op(input bit w16, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b, input bit mid);
        int w, k, busy_cnt, lat;
        logic [31:0] exp;
        w   = w16 ? 16 : 8;
        exp = model(w, op, {16'h0, a}, {16'h0, b});
        lat = model_lat(w, op, {16'h0, b});
        use16 = w16;
        k = 0;
        while (c_state != 3'b000 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("idle_before_start", {29'h0, c_state}, 32'h0);
        a_in = a; b_in = b; op_in = op;
        if (w16) start16 = 1'b1; else start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        a_in = 16'($urandom); b_in = 16'($urandom); op_in = 2'($urandom);
        check("dbz_cleared_on_start", {31'h0, c_dbz}, 32'h0);
        k = 0; busy_cnt = 0;
        while (!c_done && k < 40) begin
            if (c_busy) busy_cnt++;
            if (mid && k == 2) begin
                if (w16) start16 = 1'b1; else start8 = 1'b1;
            end else begin
                start8 = 1'b0; start16 = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start8 = 1'b0; start16 = 1'b0;
        check("latency", k, lat);
        check("busy_cycles", busy_cnt, lat);
        check("result", c_result, exp);
        check("div_by_zero", {31'h0, c_dbz}, {31'h0, (op == 2'b11 && (b & 16'((32'h1 << w) - 1)) == 0)});
        check("state_done", {29'h0, c_state}, 32'h4);
        @(negedge clk);
        check("done_one_cycle", {31'h0, c_done}, 32'h0);
        check("state_back_idle", {29'h0, c_state}, 32'h0);
        check("result_held", c_result, exp);
    endtask

    initial begin
        int pulses;
        logic [1:0] rop;
        logic [15:0] ra, rb;
        rst = 1'b1; start8 = 1'b0; start16 = 1'b0;
        a_in = '0; b_in = '0; op_in = '0;
        repeat (3) @(negedge clk);

        // Reset state of both instances
        check("rst_result8",  {16'h0, result8}, 32'h0);
        check("rst_state8",   {29'h0, state8}, 32'h0);
        check("rst_flags8",   {29'h0, busy8, done8, dbz8}, 32'h0);
        check("rst_result16", result16, 32'h0);
        check("rst_flags16",  {26'h0, state16, busy16, done16, dbz16}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases from the plan
        run_op(1'b0, 2'b00, 16'd200, 16'd100, 1'b0);
        check("add_200_100", c_result, 32'h012C);
        run_op(1'b0, 2'b01, 16'd15, 16'd8, 1'b0);
        run_op(1'b0, 2'b01, 16'd8, 16'd15, 1'b0);
        check("sub_8_15", c_result, 32'hFFF9);
        run_op(1'b0, 2'b10, 16'd255, 16'd255, 1'b0);
        check("mul_255_255", c_result, 32'hFE01);
        run_op(1'b0, 2'b10, 16'd3, 16'd4, 1'b0);
        run_op(1'b0, 2'b11, 16'd200, 16'd7, 1'b0);
        check("div_200_7", c_result, 32'h041C);
        run_op(1'b0, 2'b11, 16'd5, 16'd0, 1'b0);
        check("div_5_0", c_result, 32'h05FF);
        check("div_5_0_flag", {31'h0, c_dbz}, 32'h1);
        run_op(1'b0, 2'b00, 16'd1, 16'd2, 1'b0);
        run_op(1'b0, 2'b11, 16'd250, 16'd9, 1'b1);

        // Reset during the 4th MUL iteration drops the op
        use16 = 1'b0;
        a_in = 16'd255; b_in = 16'd255; op_in = 2'b10; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_result", c_result, 32'h0);
        check("midrst_state", {29'h0, c_state}, 32'h0);
        check("midrst_flags", {29'h0, c_busy, c_done, c_dbz}, 32'h0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (c_done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        run_op(1'b0, 2'b00, 16'd1, 16'd1, 1'b0);
        check("add_1_1", c_result, 32'h2);

        // WIDTH=16 regression
        run_op(1'b1, 2'b10, 16'hFFFF, 16'd2, 1'b0);
        check("w16_mul", c_result, 32'h0001_FFFE);
        run_op(1'b1, 2'b11, 16'hFFFF, 16'd0, 1'b0);
        run_op(1'b1, 2'b01, 16'd3, 16'd5, 1'b0);

        // Randomized ops on both widths
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom);
            ra  = 16'($urandom);
            rb  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            run_op(i[0], rop, ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
